// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS control path:
//   - ALU operation encodings (must match the ALU exactly)
//   - 4-bit FSM state encoding (FETCH is 0 so a reset state reads as 0)
//   - opcode / funct constants
//   - pc_source and alu_src_b mux encodings
//   - helper predicates on opcodes
// -----------------------------------------------------------------------------
package mips_pkg;

    // ALU operation encoding
    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_NOR = 3'b110;

    // FSM state encoding
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BEQ      = 4'd10,
        S_JMP      = 4'd11,
        S_EXC      = 4'd12
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;

    // pc_source encoding
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    // alu_src_b encoding
    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_SIMM = 2'b10;
    localparam logic [1:0] SRCB_ZIMM = 2'b11;

    // True for the immediate ALU instructions handled by I_EXEC
    function automatic logic is_itype(input logic [5:0] opcode);
        logic hit;
        case (opcode)
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: hit = 1'b1;
            default:                           hit = 1'b0;
        endcase
        return hit;
    endfunction

    // True for the memory instructions handled by MEM_ADDR
    function automatic logic is_mem(input logic [5:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// -----------------------------------------------------------------------------
// mips_alu_dec
// Combinational R-type funct -> ALU operation decoder.
// Ports:
//   funct     in  6 : instr[5:0]
//   alu_op    out 3 : ALU operation (NOP for unsupported funct codes)
//   is_signed out 1 : funct is a trapping signed op (add / sub only)
// -----------------------------------------------------------------------------
module mips_alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       is_signed
);

    // funct decode; addu/subu share the ALU op with add/sub but never trap
    always_comb begin
        alu_op    = ALU_NOP;
        is_signed = 1'b0;
        case (funct)
            F_ADD: begin
                alu_op    = ALU_ADD;
                is_signed = 1'b1;
            end
            F_ADDU: alu_op = ALU_ADD;
            F_SUB: begin
                alu_op    = ALU_SUB;
                is_signed = 1'b1;
            end
            F_SUBU: alu_op = ALU_SUB;
            F_AND:  alu_op = ALU_AND;
            F_OR:   alu_op = ALU_OR;
            F_XOR:  alu_op = ALU_XOR;
            F_NOR:  alu_op = ALU_NOR;
            default: begin
                alu_op    = ALU_NOP;
                is_signed = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// -----------------------------------------------------------------------------
// mips_mc_control
// Multi-cycle MIPS control FSM. Sequences fetch, decode, execute, memory and
// write-back, driving the ALU op / operand muxes and all datapath strobes.
//
// Configuration macro: MIPS_OVF_TRAP_EN
//   defined   : signed add/sub/addi with overflow go to EXC instead of WB
//   undefined : overflow is ignored, EXC is not built, exc is tied to 0
//
// Parameters:
//   EXC_VEC_SEL : pc_source value selecting the exception vector
// Ports:
//   clk, rst (sync, active-high)
//   instr[31:0], zero, overflow, mem_ready        : inputs
//   mem_read, mem_write, i_or_d, ir_write          : memory / IR strobes
//   pc_write, pc_write_cond, pc_source[1:0]        : PC update control
//   alu_src_a, alu_src_b[1:0], alu_op[2:0]         : ALU control
//   reg_write, reg_dst, mem_to_reg                 : register-file control
//   exc                                            : overflow trap taken
//   state[3:0]                                     : current state (debug)
//
// Outputs decode combinationally from the state register (ir_write/pc_write
// in FETCH also depend on mem_ready). All outputs read 0 while rst is high.
// instr is not latched; it must stay stable from DECODE to instruction end.
// -----------------------------------------------------------------------------
module mips_mc_control
    import mips_pkg::*;
#(
    parameter logic [1:0] EXC_VEC_SEL = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        overflow,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_source,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        exc,
    output logic [3:0]  state
);

    state_t      state_r;
    state_t      state_next_s;

    logic [5:0]  opcode_s;
    logic [2:0]  r_alu_op_s;
    logic        r_signed_s;
    logic        trap_r_s;
    logic        trap_i_s;

    // Un-gated decoded outputs
    logic        mem_read_s;
    logic        mem_write_s;
    logic        i_or_d_s;
    logic        ir_write_s;
    logic        pc_write_s;
    logic        pc_write_cond_s;
    logic [1:0]  pc_source_s;
    logic        alu_src_a_s;
    logic [1:0]  alu_src_b_s;
    logic [2:0]  alu_op_s;
    logic        reg_write_s;
    logic        reg_dst_s;
    logic        mem_to_reg_s;
    logic        exc_s;

    // Instruction fields the controller does not decode, and the branch
    // condition (the datapath combines zero with pc_write_cond itself)
    logic        unused_fields_s;

    assign opcode_s        = instr[31:26];
    assign unused_fields_s = (^instr[25:6]) ^ zero;

    mips_alu_dec u_alu_dec (
        .funct     (instr[5:0]),
        .alu_op    (r_alu_op_s),
        .is_signed (r_signed_s)
    );

`ifdef MIPS_OVF_TRAP_EN
    assign trap_r_s = overflow & r_signed_s;
    assign trap_i_s = overflow & (opcode_s == OP_ADDI);
`else
    logic unused_trap_s;
    assign unused_trap_s = overflow ^ r_signed_s ^ (^EXC_VEC_SEL);
    assign trap_r_s      = 1'b0;
    assign trap_i_s      = 1'b0;
`endif

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and output decode; every output defaults to 0
    always_comb begin
        state_next_s    = state_r;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        i_or_d_s        = 1'b0;
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        pc_source_s     = PCSRC_ALU;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = SRCB_RT;
        alu_op_s        = ALU_NOP;
        reg_write_s     = 1'b0;
        reg_dst_s       = 1'b0;
        mem_to_reg_s    = 1'b0;
        exc_s           = 1'b0;

        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                i_or_d_s    = 1'b0;
                alu_src_a_s = 1'b0;
                alu_src_b_s = SRCB_FOUR;
                alu_op_s    = ALU_ADD;
                // IR load and PC+4 only commit on the completing cycle
                ir_write_s  = mem_ready;
                pc_write_s  = mem_ready;
                if (mem_ready) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end

            S_DECODE: begin
                // Precompute the branch target into ALUOut
                alu_src_b_s = SRCB_SIMM;
                alu_op_s    = ALU_ADD;
                if (opcode_s == OP_RTYPE) begin
                    state_next_s = S_R_EXEC;
                end else if (is_mem(opcode_s)) begin
                    state_next_s = S_MEM_ADDR;
                end else if (opcode_s == OP_BEQ) begin
                    state_next_s = S_BEQ;
                end else if (opcode_s == OP_J) begin
                    state_next_s = S_JMP;
                end else if (is_itype(opcode_s)) begin
                    state_next_s = S_I_EXEC;
                end else begin
                    // Unknown opcode: silently drop and refetch
                    state_next_s = S_FETCH;
                end
            end

            S_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_SIMM;
                alu_op_s    = ALU_ADD;
                if (opcode_s == OP_LW) begin
                    state_next_s = S_MEM_RD;
                end else if (opcode_s == OP_SW) begin
                    state_next_s = S_MEM_WR;
                end else begin
                    state_next_s = S_FETCH;
                end
            end

            S_MEM_RD: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_MEM_WB;
                end else begin
                    state_next_s = S_MEM_RD;
                end
            end

            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b0;
                mem_to_reg_s = 1'b1;
                state_next_s = S_FETCH;
            end

            S_MEM_WR: begin
                mem_write_s = 1'b1;
                i_or_d_s    = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEM_WR;
                end
            end

            S_R_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_RT;
                alu_op_s    = r_alu_op_s;
                if (trap_r_s) begin
                    state_next_s = S_EXC;
                end else begin
                    state_next_s = S_R_WB;
                end
            end

            S_R_WB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b1;
                mem_to_reg_s = 1'b0;
                state_next_s = S_FETCH;
            end

            S_I_EXEC: begin
                alu_src_a_s = 1'b1;
                case (opcode_s)
                    OP_ADDI: begin
                        alu_src_b_s = SRCB_SIMM;
                        alu_op_s    = ALU_ADD;
                    end
                    OP_ANDI: begin
                        alu_src_b_s = SRCB_ZIMM;
                        alu_op_s    = ALU_AND;
                    end
                    OP_ORI: begin
                        alu_src_b_s = SRCB_ZIMM;
                        alu_op_s    = ALU_OR;
                    end
                    OP_XORI: begin
                        alu_src_b_s = SRCB_ZIMM;
                        alu_op_s    = ALU_XOR;
                    end
                    default: begin
                        alu_src_b_s = SRCB_RT;
                        alu_op_s    = ALU_NOP;
                    end
                endcase
                if (trap_i_s) begin
                    state_next_s = S_EXC;
                end else begin
                    state_next_s = S_I_WB;
                end
            end

            S_I_WB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b0;
                state_next_s = S_FETCH;
            end

            S_BEQ: begin
                alu_src_a_s     = 1'b1;
                alu_src_b_s     = SRCB_RT;
                alu_op_s        = ALU_SUB;
                pc_write_cond_s = 1'b1;
                pc_source_s     = PCSRC_ALUOUT;
                state_next_s    = S_FETCH;
            end

            S_JMP: begin
                pc_write_s   = 1'b1;
                pc_source_s  = PCSRC_JUMP;
                state_next_s = S_FETCH;
            end

`ifdef MIPS_OVF_TRAP_EN
            S_EXC: begin
                exc_s        = 1'b1;
                pc_write_s   = 1'b1;
                pc_source_s  = EXC_VEC_SEL;
                state_next_s = S_FETCH;
            end
`endif

            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

    // While rst is high every output, including the debug state, reads 0
    assign mem_read      = ~rst & mem_read_s;
    assign mem_write     = ~rst & mem_write_s;
    assign i_or_d        = ~rst & i_or_d_s;
    assign ir_write      = ~rst & ir_write_s;
    assign pc_write      = ~rst & pc_write_s;
    assign pc_write_cond = ~rst & pc_write_cond_s;
    assign pc_source     = rst ? 2'b00 : pc_source_s;
    assign alu_src_a     = ~rst & alu_src_a_s;
    assign alu_src_b     = rst ? 2'b00 : alu_src_b_s;
    assign alu_op        = rst ? 3'b000 : alu_op_s;
    assign reg_write     = ~rst & reg_write_s;
    assign reg_dst       = ~rst & reg_dst_s;
    assign mem_to_reg    = ~rst & mem_to_reg_s;
    assign exc           = ~rst & exc_s;
    assign state         = rst ? 4'd0 : state_r;

endmodule
